// File: rtl/sym_vn_lut_out_gen.sv
// Multi-port symmetric VN LUT output stage: folds (y0, y1) onto a half-symmetric
// ping-pong LUT, reads it over a 3-stage pipeline and un-folds the result.
module sym_vn_lut_out_gen #(
  parameter int QUAN_SIZE = 3,
  parameter int PORT_NUM  = 2,
  parameter int ADDR_W    = 2*QUAN_SIZE-1,
  parameter int DEPTH     = 2**ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUM-1:0]           rd_valid_in,
  input  logic [PORT_NUM-1:0]           transpose_en_in,
  input  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in,
  input  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in,
  input  logic                          read_addr_offset,
  output logic [PORT_NUM-1:0]           rd_valid_out,
  output logic [PORT_NUM*QUAN_SIZE-1:0] t_c,
  output logic [PORT_NUM*QUAN_SIZE-1:0] t_c_din,
  output logic [PORT_NUM-1:0]           transpose_en_out,
  output logic                          read_addr_offset_out,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [QUAN_SIZE-1:0]          wr_data,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic                          shadow_loaded,
  output logic                          active_bank
);
  localparam int Q = QUAN_SIZE;

  logic [Q-1:0]     bank0 [DEPTH];
  logic [Q-1:0]     bank1 [DEPTH];
  logic [DEPTH-1:0] written_map;
  logic [DEPTH-1:0] written_map_nxt;
  logic             swap_go;
  logic             off_s0, off_s1;

  // NOTE: LUT storage carries no reset; only control and pipeline state is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (active_bank) bank0[wr_addr] <= wr_data;
      else             bank1[wr_addr] <= wr_data;
    end
  end

  assign swap_go = swap_req & shadow_loaded;

  // A write landing in the swap cycle goes to the bank that becomes active, so it is not
  // recorded in the fresh map.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    written_map_nxt = written_map;
    if (swap_go)    written_map_nxt = '0;
    else if (wr_en) written_map_nxt[wr_addr] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_bank   <= 1'b0;
      written_map   <= '0;
      shadow_loaded <= 1'b0;
      swap_ack      <= 1'b0;
    end else begin
      written_map   <= written_map_nxt;
      shadow_loaded <= &written_map_nxt;
      swap_ack      <= swap_go;
      if (swap_go) active_bank <= ~active_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_s0               <= 1'b0;
      off_s1               <= 1'b0;
      read_addr_offset_out <= 1'b0;
    end else begin
      off_s0               <= read_addr_offset;
      off_s1               <= off_s0;
      read_addr_offset_out <= off_s1;
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    logic [Q-1:0]      y0, y1;
    logic              msb;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] s0_addr;
    logic              s0_msb, s0_valid, s0_bank;
    logic [Q-1:0]      s1_word;
    logic              s1_msb, s1_valid;
    logic [Q-1:0]      s2_tc, s2_word;
    logic              s2_msb, s2_valid;

    assign y0   = y0_in[p*Q +: Q];
    assign y1   = y1_in[p*Q +: Q];
    assign msb  = transpose_en_in[p] ^ y0[Q-1];
    assign addr = {y0[Q-2:0] ^ {(Q-1){y0[Q-1]}}, msb ? ~y1 : y1};

    // Each request carries its own bank index so a swap never redirects a read in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s0_addr  <= '0;
        s0_msb   <= 1'b0;
        s0_valid <= 1'b0;
        s0_bank  <= 1'b0;
        s1_word  <= '0;
        s1_msb   <= 1'b0;
        s1_valid <= 1'b0;
        s2_tc    <= '0;
        s2_word  <= '0;
        s2_msb   <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        s0_addr  <= addr;
        s0_msb   <= msb;
        s0_valid <= rd_valid_in[p];
        s0_bank  <= active_bank;
        s1_word  <= s0_bank ? bank1[s0_addr] : bank0[s0_addr];
        s1_msb   <= s0_msb;
        s1_valid <= s0_valid;
        s2_tc    <= s1_msb ? ~s1_word : s1_word;
        s2_word  <= s1_word;
        s2_msb   <= s1_msb;
        s2_valid <= s1_valid;
      end
    end

    assign t_c[p*Q +: Q]       = s2_tc;
    assign t_c_din[p*Q +: Q]   = s2_word;
    assign transpose_en_out[p] = s2_msb;
    assign rd_valid_out[p]     = s2_valid;
  end

endmodule

// File: tb/tb_sym_vn_lut_out_gen.sv
// Directed bench for sym_vn_lut_out_gen: fold cases, two-port streaming, swap
// handshake and asynchronous reset, checked against a 3-deep expectation pipeline.
module tb_sym_vn_lut_out_gen;
  localparam int Q  = 3;
  localparam int P  = 2;
  localparam int AW = 2*Q-1;
  localparam int D  = 2**AW;

  typedef struct packed {
    logic         v;
    logic [Q-1:0] tc;
    logic [Q-1:0] din;
    logic         tr;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [P-1:0]   rd_valid_in, transpose_en_in;
  logic [P*Q-1:0] y0_in, y1_in;
  logic           read_addr_offset;
  logic [P-1:0]   rd_valid_out, transpose_en_out;
  logic [P*Q-1:0] t_c, t_c_din;
  logic           read_addr_offset_out;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [Q-1:0]   wr_data;
  logic           swap_req, swap_ack, shadow_loaded, active_bank;

  int           checks = 0;
  int           failures = 0;
  logic [Q-1:0] m0 [D];
  logic [Q-1:0] m1 [D];
  exp_t         cur [P];
  exp_t         hist [3][P];
  logic         cur_off;
  logic         hist_off [3];
  logic         act;

  sym_vn_lut_out_gen #(.QUAN_SIZE(Q), .PORT_NUM(P)) dut (
    .clk(clk), .rst(rst),
    .rd_valid_in(rd_valid_in), .transpose_en_in(transpose_en_in),
    .y0_in(y0_in), .y1_in(y1_in), .read_addr_offset(read_addr_offset),
    .rd_valid_out(rd_valid_out), .t_c(t_c), .t_c_din(t_c_din),
    .transpose_en_out(transpose_en_out), .read_addr_offset_out(read_addr_offset_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .shadow_loaded(shadow_loaded),
    .active_bank(active_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference fold: returns {sign, address}.
  function automatic logic [AW:0] ref_fold(input logic tr, input logic [Q-1:0] y0,
                                           input logic [Q-1:0] y1);
    logic         s;
    logic [Q-2:0] mag;
    logic [Q-1:0] lo;
    s   = tr ^ y0[Q-1];
    mag = y0[Q-1] ? ~y0[Q-2:0] : y0[Q-2:0];
    lo  = s ? ~y1 : y1;
    return {s, mag, lo};
  endfunction

  task automatic clear_pipe();
    for (int p = 0; p < P; p++) begin
      cur[p] = '0;
      for (int s = 0; s < 3; s++) hist[s][p] = '0;
    end
    for (int s = 0; s < 3; s++) hist_off[s] = 1'b0;
    cur_off = 1'b0;
  endtask

  task automatic clear_reads();
    rd_valid_in = '0;
    for (int p = 0; p < P; p++) cur[p].v = 1'b0;
  endtask

  task automatic drive_port(input int p, input logic tr, input logic [Q-1:0] y0,
                            input logic [Q-1:0] y1, input logic [Q-1:0] e_din,
                            input logic [Q-1:0] e_tc, input logic e_tr);
    rd_valid_in[p]     = 1'b1;
    transpose_en_in[p] = tr;
    y0_in[p*Q +: Q]    = y0;
    y1_in[p*Q +: Q]    = y1;
    cur[p].v   = 1'b1;
    cur[p].din = e_din;
    cur[p].tc  = e_tc;
    cur[p].tr  = e_tr;
  endtask

  // One clock: the request captured two edges ago must now be at the outputs.
  task automatic step();
    @(posedge clk);
    for (int p = 0; p < P; p++) begin
      hist[2][p] = hist[1][p];
      hist[1][p] = hist[0][p];
      hist[0][p] = cur[p];
    end
    hist_off[2] = hist_off[1];
    hist_off[1] = hist_off[0];
    hist_off[0] = cur_off;
    #1;
    for (int p = 0; p < P; p++) begin
      check($sformatf("vld%0d", p), rd_valid_out[p], hist[2][p].v);
      if (hist[2][p].v) begin
        check($sformatf("tc%0d", p), t_c[p*Q +: Q], hist[2][p].tc);
        check($sformatf("din%0d", p), t_c_din[p*Q +: Q], hist[2][p].din);
        check($sformatf("tr%0d", p), transpose_en_out[p], hist[2][p].tr);
      end
    end
    check("offset", read_addr_offset_out, hist_off[2]);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [Q-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic fill_and_swap(input logic sel);
    bit got;
    int n;
    for (int a = 0; a < D; a++) wr(AW'(a), sel ? m1[a] : m0[a]);
    swap_req = 1'b1;
    got = 0;
    n = 0;
    while (n < 8 && !got) begin
      step();
      n++;
      if (swap_ack === 1'b1) got = 1;
    end
    check("fill_swap_ack", 32'(got), 32'd1);
    swap_req = 1'b0;
    act = ~act;
    check("fill_active", active_bank, act);
  endtask

  initial begin
    logic [AW:0]  f;
    logic [5:0]   iv;
    logic [Q-1:0] a0, b0, a1, b1;
    logic         t0, t1;

    rst = 1'b1; rd_valid_in = '0; transpose_en_in = '0; y0_in = '0; y1_in = '0;
    read_addr_offset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    act = 1'b0;
    clear_pipe();
    for (int a = 0; a < D; a++) begin
      m0[a] = Q'((a ^ 5) & 7);
      m1[a] = Q'((a * 5 + 3) & 7);
    end
    m0[26] = 3'b101; m0[29] = 3'b001; m0[15] = 3'b010;

    #2;
    check("rst_valid", rd_valid_out, 0);
    check("rst_tc", t_c, 0);
    check("rst_active", active_bank, 0);
    check("rst_loaded", shadow_loaded, 0);
    check("rst_ack", swap_ack, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    fill_and_swap(1'b1);   // bank1 loaded, becomes active
    fill_and_swap(1'b0);   // bank0 loaded, becomes active again

    // Directed fold cases on port 0, back to back.
    drive_port(0, 1'b0, 3'b011, 3'b010, 3'b101, 3'b101, 1'b0);   // addr 26
    read_addr_offset = 1'b1; cur_off = 1'b1;
    step();
    drive_port(0, 1'b1, 3'b011, 3'b010, 3'b001, 3'b110, 1'b1);   // addr 29
    read_addr_offset = 1'b0; cur_off = 1'b0;
    step();
    drive_port(0, 1'b0, 3'b110, 3'b000, 3'b010, 3'b101, 1'b1);   // addr 15
    step();
    clear_reads();
    repeat (3) step();

    // Both ports streaming different addresses every cycle.
    for (int i = 0; i < 64; i++) begin
      iv = 6'(i);
      a0 = iv[2:0]; b0 = iv[5:3]; t0 = iv[0] ^ iv[3];
      a1 = Q'((i * 5 + 3) & 7); b1 = Q'((i * 3 + 1) & 7); t1 = iv[1];
      f = ref_fold(t0, a0, b0);
      drive_port(0, t0, a0, b0, m0[f[AW-1:0]], f[AW] ? ~m0[f[AW-1:0]] : m0[f[AW-1:0]], f[AW]);
      f = ref_fold(t1, a1, b1);
      drive_port(1, t1, a1, b1, m0[f[AW-1:0]], f[AW] ? ~m0[f[AW-1:0]] : m0[f[AW-1:0]], f[AW]);
      read_addr_offset = iv[0]; cur_off = iv[0];
      step();
    end
    clear_reads();
    read_addr_offset = 1'b0; cur_off = 1'b0;
    repeat (3) step();

    // Swap handshake: 31 of 32 entries, then request; no swap may happen yet.
    for (int a = 0; a < D; a++) m1[a] = Q'((a + 2) & 7);
    for (int a = 0; a < D-1; a++) wr(AW'(a), m1[a]);
    swap_req = 1'b1;
    repeat (3) begin
      step();
      check("wait_ack", swap_ack, 0);
      check("wait_active", active_bank, 0);
      check("wait_loaded", shadow_loaded, 0);
    end
    drive_port(0, 1'b0, 3'b011, 3'b010, 3'b101, 3'b101, 1'b0);   // bank0[26]
    wr(AW'(D-1), m1[D-1]);
    check("last_loaded", shadow_loaded, 1);
    check("last_ack", swap_ack, 0);
    check("last_active", active_bank, 0);
    step();                                                     // swap edge, read still bank0
    check("swap_ack", swap_ack, 1);
    check("swap_active", active_bank, 1);
    check("swap_loaded", shadow_loaded, 0);
    swap_req = 1'b0;
    drive_port(0, 1'b0, 3'b011, 3'b010, 3'b100, 3'b100, 1'b0);   // bank1[26]
    step();
    check("ack_pulse_end", swap_ack, 0);
    clear_reads();
    repeat (3) step();

    // Reset with valid reads in flight on both ports.
    drive_port(0, 1'b0, 3'b011, 3'b010, 3'b100, 3'b100, 1'b0);   // bank1[26]
    drive_port(1, 1'b0, 3'b000, 3'b001, 3'b011, 3'b011, 1'b0);   // bank1[1]
    read_addr_offset = 1'b1; cur_off = 1'b1;
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", rd_valid_out, 0);
    check("mid_rst_tc", t_c, 0);
    check("mid_rst_din", t_c_din, 0);
    check("mid_rst_tr", transpose_en_out, 0);
    check("mid_rst_off", read_addr_offset_out, 0);
    check("mid_rst_active", active_bank, 0);
    clear_reads();
    read_addr_offset = 1'b0;
    clear_pipe();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      step();
      check("post_rst_active", active_bank, 0);
      check("post_rst_loaded", shadow_loaded, 0);
      check("post_rst_ack", swap_ack, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sym_vn_lut_out_gen.md
Name: sym_vn_lut_out_gen

Overview:
- Parametrised successor of the 3-bit symmetric VN LUT output stage.
- Serves PORT_NUM read ports for messages of QUAN_SIZE bits. Each port folds its incoming message pair (y0, y1) onto the half-symmetric LUT, reads the message, and un-folds the result.
- Adds double-buffered (ping-pong) LUT banks, so the next iteration's LUT loads while the current one is read.
- Adds valid tracking through the pipeline and a swap handshake. Sits between the VN input router and the decision node.

Parameters:
- QUAN_SIZE, 3, message width in bits (≥2).
- PORT_NUM, 2, number of independent read ports.
- ADDR_W, 2*QUAN_SIZE-1, page address width.
- DEPTH, 2**ADDR_W, entries per bank.

Ports:
- clk  in  1  single clock for read and write.
- rst  in  1  asynchronous reset, active-high.
- rd_valid_in  in  PORT_NUM  per-port read request.
- transpose_en_in  in  PORT_NUM  per-port transpose enable.
- y0_in  in  PORT_NUM*QUAN_SIZE  packed y0 messages; port p occupies bits [p*Q+:Q].
- y1_in  in  PORT_NUM*QUAN_SIZE  packed y1 messages.
- read_addr_offset  in  1  side-band bit, delayed alongside the data.
- rd_valid_out  out  PORT_NUM  result valid.
- t_c  out  PORT_NUM*QUAN_SIZE  un-folded output message.
- t_c_din  out  PORT_NUM*QUAN_SIZE  raw LUT word, without complement.
- transpose_en_out  out  PORT_NUM  fold sign, forwarded to the decision node.
- read_addr_offset_out  out  1  delayed side-band bit.
- wr_en  in  1  shadow-bank write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  QUAN_SIZE  write data.
- swap_req  in  1  request a bank swap (level).
- swap_ack  out  1  one-cycle pulse when the swap is performed.
- shadow_loaded  out  1  every shadow entry has been written since the last swap.
- active_bank  out  1  index of the bank currently being read.

Behaviour:
- **Fold, combinational, per port p** (Q = QUAN_SIZE):
  - msb = transpose_en_in[p] ^ y0[Q-1].
  - y0m = y0[Q-2:0] ^ {Q-1{y0[Q-1]}}.
  - y1m = msb ? ~y1 : y1.
  - addr = {y0m, y1m}.
- **Stage 0 register:** captures addr, msb, valid, and the bank index (active_bank value in this cycle) per port. Captures read_addr_offset.
- **Stage 1 register:** LUT word = bank[bank_idx][addr], registered. msb, valid and offset are delayed alongside.
- **Stage 2 register, the outputs:**
  - t_c = msb ? ~word : word.
  - t_c_din = word.
  - transpose_en_out = msb.
  - rd_valid_out = valid.
- **Latency:** exactly 3 cycles from input to output. Full throughput: one request per port per cycle. No backpressure.
- **Invalid requests:** a request with rd_valid_in=0 still propagates data, but rd_valid_out=0. Data outputs are don't-care for checking.
- **Writes:**
  - Writes always target bank (~active_bank); the active bank is never written.
  - Write takes effect at the clock edge.
  - Sets bit wr_addr of the DEPTH-bit written map.
  - shadow_loaded = AND of the written map, registered.
- **Swap:**
  - A swap happens at the first edge where swap_req=1 and shadow_loaded=1.
  - At that edge: active_bank toggles, the written map clears, and swap_ack pulses on the next cycle for one cycle.
  - With swap_req=1 and shadow_loaded=0: the request waits and is held by the requester; no ack is given.
- **Simultaneous events:**
  - A write in the swap cycle lands in the pre-swap shadow bank, which becomes active. That write does not set the new map.
  - A read captured in the swap cycle uses the pre-swap active bank.
  - Reads captured earlier finish on their captured bank index.
  - A read from stage 1 in the same cycle as a write to the same bank and entry cannot occur, because writes never hit an active-captured bank unless a swap has already happened. If it does occur, the read returns the old data.
- **Reset (asynchronous):** clears all pipeline registers, so every output is 0. active_bank=0, the written map is 0, shadow_loaded=0, swap_ack=0. LUT contents are not reset.
- **Reset mid-operation:** in-flight requests are discarded, with no valid out. A pending swap is cancelled.

Test Plan:
- **Fold, no transpose, Q=3:** preload bank0[26]=3'b101; send y0=011, y1=010, tr=0, valid on port0 → after 3 cycles rd_valid_out[0]=1, t_c=101, t_c_din=101, transpose_en_out=0.
- **Transpose set:** bank0[29]=001; send y0=011, y1=010, tr=1 → addr 29, t_c=110, t_c_din=001, transpose_en_out=1.
- **Negative y0:** y0=110, y1=000, tr=0 → msb=1, y0m=01, y1m=111, addr=01111=15; bank0[15]=010 → t_c=101, transpose_en_out=1.
- **Port independence, PORT_NUM=2:** issue different addresses on both ports each cycle for 64 cycles → every output matches the model at 3-cycle latency, with no cross-port corruption.
- **Swap handshake:**
  - Write 31 of 32 shadow entries, then assert swap_req → no ack and active_bank=0.
  - Write the last entry → shadow_loaded=1; swap performed; swap_ack pulses one cycle; active_bank=1.
  - A read issued one cycle before the swap returns bank0 data; a read issued after the swap returns bank1 data.
- **Reset:** assert rst mid-stream with valids in flight → outputs are 0 immediately. After release, active_bank=0, shadow_loaded=0, and no stale rd_valid_out.
